// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for instruction fetch and load/store
// Optional MEM_ARB_RR_EN: round-robin tie breaking instead of fixed data priority.
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_done,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic [DW-1:0] dm_rdata,
   output logic          dm_done,
   output logic          stall,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic          err
);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t        state;
   logic          gnt_dm;
   logic [CW-1:0] wait_cnt;
   logic          pick_dm;
   logic          timed_out;

`ifdef MEM_ARB_RR_EN
   logic          last_dm;

   // On a tie the requester that did not win last time gets the port.
   always_comb begin
      pick_dm = dm_req;
      if (dm_req && if_req) pick_dm = ~last_dm;
   end
`else
   always_comb begin
      pick_dm = dm_req;
   end
`endif

   assign timed_out = (TIMEOUT != 0) && (wait_cnt == CW'(TIMEOUT));
   assign stall     = (if_req & ~if_done) | (dm_req & ~dm_done);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         gnt_dm    <= 1'b0;
         wait_cnt  <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
         if_done   <= 1'b0;
         dm_done   <= 1'b0;
         err       <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_dm   <= 1'b0;
`endif
      end else begin
         if_done <= 1'b0;
         dm_done <= 1'b0;
         case (state)
            IDLE: begin
               if (if_req || dm_req) begin
                  gnt_dm  <= pick_dm;
                  mem_req <= 1'b1;
                  if (pick_dm) begin
                     mem_we    <= dm_we;
                     mem_addr  <= dm_addr;
                     mem_wdata <= dm_wdata;
                  end else begin
                     mem_we    <= 1'b0;
                     mem_addr  <= if_addr;
                     mem_wdata <= '0;
                  end
`ifdef MEM_ARB_RR_EN
                  last_dm <= pick_dm;
`endif
                  state <= BUSY;
               end
            end
            BUSY: begin
               // A ready in the same cycle the watchdog expires still completes the access.
               if (mem_ready) begin
                  if (gnt_dm) begin
                     if (!mem_we) dm_rdata <= mem_rdata;
                     dm_done <= 1'b1;
                  end else begin
                     if_rdata <= mem_rdata;
                     if_done  <= 1'b1;
                  end
                  mem_req <= 1'b0;
                  state   <= RESP;
               end else if (timed_out) begin
                  err <= 1'b1;
                  if (gnt_dm) begin
                     dm_rdata <= '0;
                     dm_done  <= 1'b1;
                  end else begin
                     if_rdata <= '0;
                     if_done  <= 1'b1;
                  end
                  mem_req <= 1'b0;
                  state   <= RESP;
               end else if (wait_cnt != '1) begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            RESP: begin
               wait_cnt <= '0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
// Directed timing cases followed by two randomized requesters against a memory model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          if_req, dm_req, dm_we, mem_ready;
   logic [AW-1:0] if_addr, dm_addr;
   logic [DW-1:0] dm_wdata, mem_rdata;
   logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
   logic [AW-1:0] mem_addr;
   logic          if_done, dm_done, stall, mem_req, mem_we, err;

   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_done(dm_done), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Reference memory (updated when a store is issued) and the physical memory
   // the responder serves (updated only from what the DUT drives onto the bus).
   logic [DW-1:0] ref_mem  [logic [AW-1:0]];
   logic [DW-1:0] phys_mem [logic [AW-1:0]];
   logic [DW-1:0] if_q[$];
   logic [DW-1:0] dm_q[$];
   logic [DW-1:0] dm_model;

   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0001;
   endfunction
   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction
   function automatic logic [DW-1:0] phys_rd(input logic [AW-1:0] a);
      return phys_mem.exists(a) ? phys_mem[a] : init_val(a);
   endfunction

   task automatic issue_if(input logic [AW-1:0] a);
      if_addr = a;
      if_req  = 1'b1;
      if_q.push_back(ref_rd(a));
   endtask

   task automatic issue_dm(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      logic [DW-1:0] e;
      dm_we    = we;
      dm_addr  = a;
      dm_wdata = wd;
      dm_req   = 1'b1;
      if (we) begin
         ref_mem[a] = wd;
         e = dm_model;
      end else begin
         e = ref_rd(a);
         dm_model = e;
      end
      dm_q.push_back(e);
   endtask

   int   cyc = 0;
   logic s_if, s_dm;
   always @(posedge clk) begin
      cyc  <= cyc + 1;
      s_if <= if_req;
      s_dm <= dm_req;
   end

   // Memory responder: checks each new command against the arbitration rule,
   // then answers after a fixed or random number of wait states.
   logic last_w_dm = 1'b0;
   logic w_dm;
   bit   busy = 1'b0;
   bit   hang = 1'b0;
   bit   noise = 1'b0;
   int   wcnt = 0;
   int   fixed_wait = 0;
   int   ready_cyc = -10;

   always @(negedge clk) begin
      mem_ready = 1'b0;
      if (!mem_req) begin
         busy = 1'b0;
         if (noise) begin
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
         end
      end else begin
         if (!busy) begin
            busy = 1'b1;
            wcnt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
            if (s_if && s_dm) begin
`ifdef MEM_ARB_RR_EN
               w_dm = ~last_w_dm;
`else
               w_dm = 1'b1;
`endif
            end else begin
               w_dm = s_dm;
            end
            last_w_dm = w_dm;
            if (w_dm)
               chk("mem_cmd_dm", 96'({mem_we, mem_addr, mem_wdata}), 96'({dm_we, dm_addr, dm_wdata}));
            else
               chk("mem_cmd_if", 96'({mem_we, mem_addr, mem_wdata}), 96'({1'b0, if_addr, 32'h0}));
         end
         if (!hang) begin
            if (wcnt == 0) begin
               mem_ready = 1'b1;
               ready_cyc = cyc;
               if (mem_we) phys_mem[mem_addr] = mem_wdata;
               else        mem_rdata = phys_rd(mem_addr);
            end else begin
               wcnt--;
            end
         end
      end
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (!rst) begin
         if (if_done) begin
            if (if_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL if_done_unexpected: got a done pulse, required none");
            end else begin
               chk("if_rdata", 96'(if_rdata), 96'(if_q.pop_front()));
            end
            if (!hang) chk("if_latency", 96'(cyc), 96'(ready_cyc + 1));
         end
         if (dm_done) begin
            if (dm_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL dm_done_unexpected: got a done pulse, required none");
            end else begin
               chk("dm_rdata", 96'(dm_rdata), 96'(dm_q.pop_front()));
            end
            if (!hang) chk("dm_latency", 96'(cyc), 96'(ready_cyc + 1));
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; if_req = 1'b0; dm_req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      if_q.delete(); dm_q.delete();
      dm_model = '0; last_w_dm = 1'b0;
   endtask

   task automatic run_fetch(input int n_txn);
      int t;
      for (int n = 0; n < n_txn; n++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         issue_if(AW'($urandom_range(0, 63) * 4));
         t = 0;
         do begin @(negedge clk); t++; end while (!if_done && t < 300);
         if (!if_done) begin
            checks++; errors++;
            $display("FAIL fetch_wait: no if_done after %0d cycles, required a done pulse", t);
         end
         if_req = 1'b0;
      end
   endtask

   task automatic run_data(input int n_txn);
      int t;
      for (int n = 0; n < n_txn; n++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         issue_dm(1'($urandom_range(0, 1)), AW'(32'h1000 + $urandom_range(0, 15) * 4), $urandom);
         t = 0;
         do begin @(negedge clk); t++; end while (!dm_done && t < 300);
         if (!dm_done) begin
            checks++; errors++;
            $display("FAIL data_wait: no dm_done after %0d cycles, required a done pulse", t);
         end
         dm_req = 1'b0;
      end
   endtask

   initial begin
      int dm_c[$];
      int if_c[$];
      int t;
      if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
      mem_ready = 0; mem_rdata = '0; dm_model = '0;
      do_reset();

      chk("rst_mem_req", 96'(mem_req), 96'(0));
      chk("rst_mem_we", 96'(mem_we), 96'(0));
      chk("rst_mem_addr", 96'(mem_addr), 96'(0));
      chk("rst_mem_wdata", 96'(mem_wdata), 96'(0));
      chk("rst_if_rdata", 96'(if_rdata), 96'(0));
      chk("rst_dm_rdata", 96'(dm_rdata), 96'(0));
      chk("rst_if_done", 96'(if_done), 96'(0));
      chk("rst_dm_done", 96'(dm_done), 96'(0));
      chk("rst_err", 96'(err), 96'(0));
      chk("rst_stall", 96'(stall), 96'(0));

      // Fetch alone, memory ready in the first BUSY cycle.
      fixed_wait = 0;
      ref_mem[32'h40] = 32'h2002000A;
      phys_mem[32'h40] = 32'h2002000A;
      issue_if(32'h40);
      #1 chk("fetch_stall_c0", 96'(stall), 96'(1));
      @(negedge clk);
      chk("fetch_mem_req_c1", 96'(mem_req), 96'(1));
      chk("fetch_mem_we_c1", 96'(mem_we), 96'(0));
      chk("fetch_done_c1", 96'(if_done), 96'(0));
      @(negedge clk);
      chk("fetch_done_c2", 96'(if_done), 96'(1));
      chk("fetch_rdata_c2", 96'(if_rdata), 96'(32'h2002000A));
      chk("fetch_stall_c2", 96'(stall), 96'(0));
      chk("fetch_mem_req_c2", 96'(mem_req), 96'(0));
      if_req = 1'b0;
      @(negedge clk);

      // Tie followed by a second tie.
      issue_dm(1'b0, 32'h180, 32'h0);
      issue_if(32'h44);
      #1 chk("tie_stall_c0", 96'(stall), 96'(1));
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         if (dm_done) begin
            dm_c.push_back(c);
            if (dm_c.size() == 1) issue_dm(1'b0, 32'h184, 32'h0);
            else dm_req = 1'b0;
         end
         if (if_done) begin
            if_c.push_back(c);
            if_req = 1'b0;
         end
      end
      chk("tie_dm_count", 96'(dm_c.size()), 96'(2));
      chk("tie_if_count", 96'(if_c.size()), 96'(1));
      if (dm_c.size() == 2 && if_c.size() == 1) begin
         chk("tie_dm_first", 96'(dm_c[0]), 96'(2));
`ifdef MEM_ARB_RR_EN
         chk("tie_if_cycle", 96'(if_c[0]), 96'(5));
         chk("tie_dm_second", 96'(dm_c[1]), 96'(8));
`else
         chk("tie_dm_second", 96'(dm_c[1]), 96'(5));
         chk("tie_if_cycle", 96'(if_c[0]), 96'(8));
`endif
      end

      // Store with three wait states; dm_rdata must keep the last load value.
      fixed_wait = 3;
      issue_dm(1'b1, 32'h100, 32'hDEADBEEF);
      #1 chk("store_stall_c0", 96'(stall), 96'(1));
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (c <= 4) begin
            chk("store_mem_req", 96'(mem_req), 96'(1));
            chk("store_mem_we", 96'(mem_we), 96'(1));
            chk("store_mem_wdata", 96'(mem_wdata), 96'(32'hDEADBEEF));
            chk("store_stall", 96'(stall), 96'(1));
            chk("store_done_early", 96'(dm_done), 96'(0));
         end else begin
            chk("store_done_c5", 96'(dm_done), 96'(1));
            chk("store_rdata_kept", 96'(dm_rdata), 96'(init_val(32'h184)));
         end
      end
      dm_req = 1'b0;
      @(negedge clk);

      // Watchdog: load that never sees mem_ready.
      hang = 1'b1;
      issue_dm(1'b0, 32'h1C0, 32'h0);
      void'(dm_q.pop_back());
      dm_q.push_back('0);
      dm_model = '0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c <= 5) begin
            chk("to_mem_req", 96'(mem_req), 96'(1));
            chk("to_err_early", 96'(err), 96'(0));
            chk("to_done_early", 96'(dm_done), 96'(0));
         end else begin
            chk("to_done", 96'(dm_done), 96'(1));
            chk("to_rdata_zero", 96'(dm_rdata), 96'(0));
            chk("to_err", 96'(err), 96'(1));
            chk("to_mem_req_drop", 96'(mem_req), 96'(0));
         end
      end
      dm_req = 1'b0;
      @(negedge clk);
      hang = 1'b0;

      // err stays set across a later normal access.
      fixed_wait = 1;
      issue_if(32'h4C);
      t = 0;
      do begin @(negedge clk); t++; end while (!if_done && t < 20);
      chk("post_to_fetch_done", 96'(if_done), 96'(1));
      if_req = 1'b0;
      @(negedge clk);
      chk("err_sticky", 96'(err), 96'(1));

      // Reset in the second BUSY cycle of a fetch abandons it.
      fixed_wait = 3;
      issue_if(32'h48);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rstbusy_mem_req", 96'(mem_req), 96'(0));
      chk("rstbusy_err", 96'(err), 96'(0));
      chk("rstbusy_if_rdata", 96'(if_rdata), 96'(0));
      rst = 1'b0;
      if_req = 1'b0;
      if_q.delete();
      dm_model = '0;
      last_w_dm = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("rstbusy_no_done", 96'(if_done), 96'(0));
      end

      // Randomized traffic with stray mem_ready outside BUSY.
      fixed_wait = -1;
      noise = 1'b1;
      fork
         run_fetch(40);
         run_data(40);
      join
      noise = 1'b0;
      repeat (4) @(negedge clk);
      chk("if_q_drained", 96'(if_q.size()), 96'(0));
      chk("dm_q_drained", 96'(dm_q.size()), 96'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: bench still running at %0t, required completion", $time);
      $fatal(1);
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-ported unified memory between the instruction-fetch path and the load/store (lw/sw) data path of the microprocessor. It serialises the two requesters onto one memory handshake, returns read data to whichever requester was granted, and produces the `stall` signal the control FSM uses to freeze the datapath while an access is outstanding. A watchdog ends any memory access that never completes.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 255, max BUSY cycles without `mem_ready`; 0 disables the watchdog

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `if_req`  in  1  fetch request, level
- `if_addr`  in  AW  fetch address
- `if_rdata`  out  DW  fetched word, valid while `if_done`
- `if_done`  out  1  fetch complete, 1-cycle pulse
- `dm_req`  in  1  data request, level
- `dm_we`  in  1  1 = store (sw), 0 = load (lw)
- `dm_addr`  in  AW  data address
- `dm_wdata`  in  DW  store data
- `dm_rdata`  out  DW  load data, valid while `dm_done`
- `dm_done`  out  1  data access complete, 1-cycle pulse
- `stall`  out  1  datapath freeze to the control FSM
- `mem_req`  out  1  memory request
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, sampled with `mem_ready`
- `mem_ready`  in  1  memory access complete
- `err`  out  1  sticky watchdog timeout flag

## Operation
- States: IDLE, BUSY, RESP.
- IDLE:
  - If neither request is asserted, stay in IDLE.
  - Otherwise pick a grant (see Configuration).
  - Register `mem_addr`, `mem_we`, and `mem_wdata` from the winner. A fetch grant forces `mem_we`=0 and `mem_wdata`=0.
  - Set `mem_req`=1 and go to BUSY.
- BUSY:
  - `mem_req` and the memory address/data outputs are held constant.
  - When `mem_ready`=1: capture `mem_rdata` into the granted requester's rdata register. Only loads update `dm_rdata`; stores leave it unchanged. Drop `mem_req` and go to RESP.
  - The wait counter increments on every BUSY cycle where `mem_ready`=0. When it reaches `TIMEOUT` (with `TIMEOUT`≠0): set `err`, load 0 into the granted requester's rdata register, drop `mem_req`, and go to RESP.
- RESP:
  - Assert the granted requester's done pulse for exactly 1 cycle.
  - Clear the wait counter and go to IDLE.
- Requester rules:
  - A requester holds req, addr, we, and wdata stable from assertion until its done pulse.
  - A req still high in the IDLE cycle after done is a new transaction.
  - A requester never raises req while its own transaction is in flight.
- `stall` = (`if_req` & ~`if_done`) | (`dm_req` & ~`dm_done`). It is combinational from registered state and the inputs.
- The non-granted requester keeps waiting and is considered in the next IDLE cycle.
- `err` is sticky and is cleared only by `rst`.
- Reset:
  - All outputs go to 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata`, `if_done`, `dm_done`, `err`.
  - State returns to IDLE, the wait counter is cleared, and `last_grant` is set to IF.
  - `rst` during BUSY or RESP abandons the access: `mem_req` is 0 on the next cycle and no done pulse is issued.

## Timing
- Request seen in IDLE at cycle 0 → `mem_req`=1 from cycle 1.
- `mem_ready` high in cycle 1+k → done high in cycle 2+k. Minimum request-to-done latency is 2 cycles.
- Back-to-back transactions: done at cycle n, IDLE at n+1, next `mem_req` at n+2. Minimum spacing between requests is 3 cycles.
- Timeout: `mem_req` stays high for `TIMEOUT`+1 cycles; done and `err` rise in the following cycle.
- `mem_ready` while not in BUSY is ignored.
- Wait counter width is clog2(`TIMEOUT`+1), with a minimum of 1. It saturates and never wraps.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - A 1-bit `last_grant` register tracks the most recent winner.
  - On a tie (both requests in the same IDLE cycle), the requester not granted last wins.
  - The first tie after reset goes to data.
- `MEM_ARB_RR_EN` undefined:
  - Fixed priority: data always wins ties.
  - `last_grant` is not implemented.
  - A fetch request can starve under continuous data traffic.

## Test plan
- Fetch alone: `if_req`=1, `if_addr`=0x40, `mem_ready` high in the first BUSY cycle with `mem_rdata`=0x2002000A → `mem_req` at cycle 1, `if_done` at cycle 2, `if_rdata`=0x2002000A, `mem_we`=0.
- Store with 3 wait states: `dm_we`=1, `dm_addr`=0x100, `dm_wdata`=0xDEADBEEF → `mem_we`=1 and `mem_wdata`=0xDEADBEEF for 4 cycles, `dm_done` at cycle 5, `dm_rdata` unchanged, `stall`=1 during cycles 0–4.
- Tie at cycle 0, memory ready immediately:
  - Without the macro: data granted first and `dm_done` at cycle 2; fetch granted at cycle 3 and `if_done` at cycle 5.
  - With `MEM_ARB_RR_EN`: same first tie; on a second tie right after, fetch wins.
- Timeout with `TIMEOUT`=4 and `mem_ready` held 0 on a load → `mem_req` high for 5 cycles, `dm_done` with `dm_rdata`=0, `err`=1 and held until `rst`.
- `rst` asserted in the 2nd BUSY cycle of a fetch → next cycle `mem_req`=0 and state IDLE; `if_done` never pulses; a fetch issued after reset completes normally.
